// File: rtl/litspin_pkg.sv
// Shared types and width helpers for the LitSpin display pipeline.
package litspin_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StShift,
    StLatch
  } column_state_t;

  function automatic int angle_width(input int nb_angles);
    return $clog2(nb_angles);
  endfunction

endpackage

// File: rtl/led_shifter.sv
// Serialises one pixel word MSB first at clk/2; drivers sample on sclk rising edges.
module led_shifter #(
  parameter int PIXEL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PIXEL_WIDTH-1:0] data,
  output logic                   sclk,
  output logic                   sdata,
  output logic                   done
);

  localparam int CntWidth = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(PIXEL_WIDTH - 1);

  logic [PIXEL_WIDTH-1:0] sr_q;
  logic [CntWidth-1:0]    bit_cnt_q;
  logic                   active_q;
  logic                   sclk_q;

  // sdata comes straight from the shift register MSB, so it is a flop output.
  assign sdata = sr_q[PIXEL_WIDTH-1];
  assign sclk  = sclk_q;
  assign done  = active_q && sclk_q && (bit_cnt_q == LastBit);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      active_q  <= 1'b0;
      sclk_q    <= 1'b0;
    end else if (load) begin
      sr_q      <= data;
      bit_cnt_q <= '0;
      active_q  <= 1'b1;
      sclk_q    <= 1'b0;
    end else if (active_q) begin
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else if (bit_cnt_q == LastBit) begin
        sclk_q   <= 1'b0;
        active_q <= 1'b0;
        sr_q     <= '0;
      end else begin
        sclk_q    <= 1'b0;
        bit_cnt_q <= bit_cnt_q + CntWidth'(1);
        sr_q      <= sr_q << 1;
      end
    end
  end

endmodule

// File: rtl/column_streamer.sv
// Fetches the framebuffer column for each new angle and streams it to the LED driver chain.
module column_streamer
  import litspin_pkg::*;
#(
  parameter int NB_ANGLES   = 128,
  parameter int NB_LEDS     = 48,
  parameter int PIXEL_WIDTH = 24,
  parameter int ANGLE_WIDTH = angle_width(NB_ANGLES),
  parameter int ADDR_WIDTH  = $clog2(NB_ANGLES * NB_LEDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ANGLE_WIDTH-1:0] angle,
  output logic                   fb_rd_en,
  output logic [ADDR_WIDTH-1:0]  fb_addr,
  input  logic [PIXEL_WIDTH-1:0] fb_rdata,
  output logic                   led_sclk,
  output logic                   led_sdata,
  output logic                   led_latch,
  output logic                   busy,
  output logic                   overrun
);

  localparam int IdxWidth = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
  localparam logic [IdxWidth-1:0] LastLed = IdxWidth'(NB_LEDS - 1);

  column_state_t          state;
  logic [ANGLE_WIDTH-1:0] prev_angle;
  logic [ANGLE_WIDTH-1:0] req_angle;
  logic [ANGLE_WIDTH-1:0] col_angle;
  logic [IdxWidth-1:0]    led_idx;
  logic                   pending;
  logic                   latch_cnt;
  logic                   change;
  logic                   consume;
  logic                   shift_done;

  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic [ANGLE_WIDTH-1:0] a,
                                                        input logic [IdxWidth-1:0] i);
    return ADDR_WIDTH'(int'(a) * NB_LEDS + int'(i));
  endfunction

  assign change  = (angle != prev_angle);
  assign consume = (state == StIdle) && pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      prev_angle <= '0;
      req_angle  <= '0;
      col_angle  <= '0;
      led_idx    <= '0;
      pending    <= 1'b0;
      latch_cnt  <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      led_latch  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      prev_angle <= angle;
      overrun    <= 1'b0;
      // A fresh change beats a same-cycle consume; only an unconsumed request is dropped.
      if (change) begin
        req_angle <= angle;
        pending   <= 1'b1;
        overrun   <= pending && !consume;
      end else if (consume) begin
        pending <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (pending) begin
            col_angle <= req_angle;
            led_idx   <= LastLed;
            fb_rd_en  <= 1'b1;
            fb_addr   <= pixel_addr(req_angle, LastLed);
            busy      <= 1'b1;
            state     <= StRead;
          end
        end
        StRead: begin
          fb_rd_en <= 1'b0;
          state    <= StWait;
        end
        StWait: state <= StShift;
        StShift: begin
          if (shift_done) begin
            if (led_idx == '0) begin
              led_latch <= 1'b1;
              latch_cnt <= 1'b0;
              state     <= StLatch;
            end else begin
              led_idx  <= led_idx - IdxWidth'(1);
              fb_rd_en <= 1'b1;
              fb_addr  <= pixel_addr(col_angle, led_idx - IdxWidth'(1));
              state    <= StRead;
            end
          end
        end
        StLatch: begin
          if (latch_cnt) begin
            led_latch <= 1'b0;
            busy      <= 1'b0;
            state     <= StIdle;
          end else begin
            latch_cnt <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  led_shifter #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .load (state == StWait),
    .data (fb_rdata),
    .sclk (led_sclk),
    .sdata(led_sdata),
    .done (shift_done)
  );

endmodule

// File: tb/tb_column_streamer.sv
// Randomised scenario bench for column_streamer with a column-level reference model.
module tb_column_streamer;

  localparam int NbAngles   = 8;
  localparam int NbLeds     = 2;
  localparam int PixelWidth = 4;
  localparam int AngleWidth = 3;
  localparam int AddrWidth  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [AngleWidth-1:0] angle = '0;
  logic                  fb_rd_en;
  logic [AddrWidth-1:0]  fb_addr;
  logic [PixelWidth-1:0] fb_rdata = '0;
  logic                  led_sclk;
  logic                  led_sdata;
  logic                  led_latch;
  logic                  busy;
  logic                  overrun;

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;

  int addr_q[$];
  int bit_q[$];
  int latch_cycles = 0;
  int ovr_cnt      = 0;
  int busy_cycles  = 0;
  logic sclk_prev  = 1'b0;

  column_streamer #(
    .NB_ANGLES  (NbAngles),
    .NB_LEDS    (NbLeds),
    .PIXEL_WIDTH(PixelWidth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .angle    (angle),
    .fb_rd_en (fb_rd_en),
    .fb_addr  (fb_addr),
    .fb_rdata (fb_rdata),
    .led_sclk (led_sclk),
    .led_sdata(led_sdata),
    .led_latch(led_latch),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Framebuffer model: one-cycle read latency, pixel word = address & 0xF.
  always @(posedge clk) begin
    if (fb_rd_en) fb_rdata <= PixelWidth'(fb_addr & 4'hF);
  end

  always @(negedge clk) begin
    if (fb_rd_en === 1'b1) addr_q.push_back(int'(fb_addr));
    if (led_sclk === 1'b1 && sclk_prev !== 1'b1) bit_q.push_back(int'(led_sdata));
    sclk_prev <= led_sclk;
    if (led_latch === 1'b1) latch_cycles <= latch_cycles + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  // Expected read addresses and serial bits for a sequence of emitted columns.
  function automatic void model_cols(input int angles[$], output string a_s, output string b_s);
    a_s = "";
    b_s = "";
    foreach (angles[i]) begin
      for (int l = NbLeds - 1; l >= 0; l--) begin
        int ad = angles[i] * NbLeds + l;
        int px = ad & 'hF;
        a_s = {a_s, $sformatf("%0d,", ad)};
        for (int b = PixelWidth - 1; b >= 0; b--) b_s = {b_s, $sformatf("%0d", (px >> b) & 1)};
      end
    end
  endfunction

  function automatic string tail_str(input int q[$], input int base, input bit commas);
    string s = "";
    for (int i = base; i < q.size(); i++) s = {s, $sformatf(commas ? "%0d," : "%0d", q[i])};
    return s;
  endfunction

  task automatic set_angle(input int v);
    @(posedge clk);
    #1;
    angle = AngleWidth'(v);
    cur   = v;
  endtask

  task automatic pick_new(input int avoid, output int v);
    do v = int'($urandom_range(0, NbAngles - 1)); while (v == avoid);
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (busy) q = 0;
      else q++;
    end
    n_vec++;
    if (q < 4) begin
      n_err++;
      $display("FAIL wait_quiet: busy still set after %0d cycles, want idle", n);
    end
  endtask

  task automatic test_reset();
    int a0, b0, bc0;
    rst   = 1'b1;
    angle = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({fb_rd_en, fb_addr, led_sclk, led_sdata, led_latch, busy, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want all zero",
               {fb_rd_en, fb_addr, led_sclk, led_sdata, led_latch, busy, overrun});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    a0  = addr_q.size();
    b0  = bit_q.size();
    bc0 = busy_cycles;
    repeat (50) @(negedge clk);
    n_vec++;
    if (addr_q.size() != a0 || bit_q.size() != b0 || busy_cycles != bc0) begin
      n_err++;
      $display("FAIL idle_at_zero: reads %0d sclk %0d busy %0d, want 0 0 0",
               addr_q.size() - a0, bit_q.size() - b0, busy_cycles - bc0);
    end
  endtask

  task automatic test_basic();
    int a0, b0, l0, cnt;
    int cols[$];
    string ea, eb;
    a0 = addr_q.size();
    b0 = bit_q.size();
    l0 = latch_cycles;
    set_angle(3);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (fb_rd_en !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_k1: rd_en %b busy %b, want 0 0", fb_rd_en, busy);
    end
    @(negedge clk);
    n_vec++;
    if (fb_rd_en !== 1'b1 || fb_addr !== 4'd7 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_k2: rd_en %b addr %0d busy %b, want 1 7 1", fb_rd_en, fb_addr, busy);
    end
    cnt = 1;
    while (busy === 1'b1 && cnt < 200) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    n_vec++;
    if (cnt != 22) begin
      n_err++;
      $display("FAIL basic_column_len: got %0d busy cycles want 22", cnt);
    end
    n_vec++;
    if (latch_cycles - l0 != 2) begin
      n_err++;
      $display("FAIL basic_latch: got %0d latch cycles want 2", latch_cycles - l0);
    end
    cols.push_back(3);
    model_cols(cols, ea, eb);
    n_vec++;
    if (tail_str(addr_q, a0, 1) != ea) begin
      n_err++;
      $display("FAIL basic_addrs: got %s want %s", tail_str(addr_q, a0, 1), ea);
    end
    n_vec++;
    if (tail_str(bit_q, b0, 0) != eb) begin
      n_err++;
      $display("FAIL basic_bits: got %s want %s", tail_str(bit_q, b0, 0), eb);
    end
    wait_quiet();
  endtask

  task automatic test_random();
    int v, a0, b0, o0;
    int cols[$];
    string ea, eb;
    for (int it = 0; it < 4; it++) begin
      a0 = addr_q.size();
      b0 = bit_q.size();
      o0 = ovr_cnt;
      pick_new(cur, v);
      set_angle(v);
      wait_quiet();
      cols.delete();
      cols.push_back(v);
      model_cols(cols, ea, eb);
      n_vec++;
      if (tail_str(addr_q, a0, 1) != ea || tail_str(bit_q, b0, 0) != eb || ovr_cnt != o0) begin
        n_err++;
        $display("FAIL random_col%0d: addrs %s bits %s ovr %0d, want %s %s 0", it,
                 tail_str(addr_q, a0, 1), tail_str(bit_q, b0, 0), ovr_cnt - o0, ea, eb);
      end
    end
  endtask

  task automatic test_overrun();
    int b1, b2, b3, a0, b0, o0;
    int cols[$];
    string ea, eb;
    a0 = addr_q.size();
    b0 = bit_q.size();
    o0 = ovr_cnt;
    pick_new(cur, b1);
    pick_new(b1, b2);
    pick_new(b2, b3);
    set_angle(b1);
    repeat (8) @(posedge clk);
    set_angle(b2);
    repeat (5) @(posedge clk);
    set_angle(b3);
    wait_quiet();
    n_vec++;
    if (ovr_cnt - o0 != 1) begin
      n_err++;
      $display("FAIL overrun_count: got %0d want 1", ovr_cnt - o0);
    end
    cols.push_back(b1);
    cols.push_back(b3);
    model_cols(cols, ea, eb);
    n_vec++;
    if (tail_str(addr_q, a0, 1) != ea || tail_str(bit_q, b0, 0) != eb) begin
      n_err++;
      $display("FAIL overrun_latest: addrs %s bits %s, want %s %s",
               tail_str(addr_q, a0, 1), tail_str(bit_q, b0, 0), ea, eb);
    end
  endtask

  task automatic test_latch_boundary();
    int c, d, a0, o0;
    int cols[$];
    string ea, eb;
    a0 = addr_q.size();
    o0 = ovr_cnt;
    pick_new(cur, c);
    pick_new(c, d);
    set_angle(c);
    repeat (2) @(posedge clk);
    repeat (20) @(posedge clk);
    set_angle(d);
    @(negedge clk);
    n_vec++;
    if (led_latch !== 1'b1) begin
      n_err++;
      $display("FAIL boundary_latch_cycle: latch %b want 1", led_latch);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (fb_rd_en !== 1'b1 || fb_addr !== AddrWidth'(d * NbLeds + NbLeds - 1)) begin
      n_err++;
      $display("FAIL boundary_next_read: rd_en %b addr %0d, want 1 %0d", fb_rd_en, fb_addr,
               d * NbLeds + NbLeds - 1);
    end
    wait_quiet();
    cols.push_back(c);
    cols.push_back(d);
    model_cols(cols, ea, eb);
    n_vec++;
    if (tail_str(addr_q, a0, 1) != ea || ovr_cnt != o0) begin
      n_err++;
      $display("FAIL boundary_cols: addrs %s ovr %0d, want %s 0", tail_str(addr_q, a0, 1),
               ovr_cnt - o0, ea);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, a0, b0, o0;
    int cols[$];
    string ea, eb;
    a0 = addr_q.size();
    b0 = bit_q.size();
    o0 = ovr_cnt;
    pick_new(cur, a);
    pick_new(a, b);
    set_angle(a);
    set_angle(b);
    wait_quiet();
    cols.push_back(a);
    cols.push_back(b);
    model_cols(cols, ea, eb);
    n_vec++;
    if (tail_str(addr_q, a0, 1) != ea || tail_str(bit_q, b0, 0) != eb || ovr_cnt != o0) begin
      n_err++;
      $display("FAIL back_to_back: addrs %s bits %s ovr %0d, want %s %s 0",
               tail_str(addr_q, a0, 1), tail_str(bit_q, b0, 0), ovr_cnt - o0, ea, eb);
    end
  endtask

  task automatic test_reset_mid();
    int a, a0, b0, l0, n;
    int cols[$];
    string ea, eb;
    l0 = latch_cycles;
    b0 = bit_q.size();
    pick_new(cur, a);
    set_angle(a);
    n = 0;
    while (bit_q.size() < b0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rst   = 1'b1;
    angle = '0;
    cur   = 0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({fb_rd_en, fb_addr, led_sclk, led_sdata, led_latch, busy, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %b want all zero",
               {fb_rd_en, fb_addr, led_sclk, led_sdata, led_latch, busy, overrun});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++;
    if (latch_cycles != l0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_latch: latch cycles %0d busy %b, want 0 0",
               latch_cycles - l0, busy);
    end
    foreach (cols[i]) cols.delete(i);
    for (int k = 0; k < 2; k++) begin
      int v = (k == 0) ? 5 : 7;
      a0 = addr_q.size();
      b0 = bit_q.size();
      set_angle(v);
      wait_quiet();
      cols.delete();
      cols.push_back(v);
      model_cols(cols, ea, eb);
      n_vec++;
      if (tail_str(addr_q, a0, 1) != ea || tail_str(bit_q, b0, 0) != eb) begin
        n_err++;
        $display("FAIL post_reset_angle%0d: addrs %s bits %s, want %s %s", v,
                 tail_str(addr_q, a0, 1), tail_str(bit_q, b0, 0), ea, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_overrun();
    test_latch_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/column_streamer.md
# column_streamer

Downstream of the angle computer in the LitSpin FPGA. Watches the registered `angle` output and, on every angle change, fetches that angle's column of `NB_LEDS` pixels from the framebuffer RAM. It serialises the pixels to the LED driver chain and pulses a latch once the whole column is shifted. It owns the framebuffer read port and the driver serial pins.

## Interface
- `NB_ANGLES`, 128: angles per turn; power of 2; `ANGLE_WIDTH = $clog2(NB_ANGLES)`.
- `NB_LEDS`, 48: pixels per column, i.e. driver chain length.
- `PIXEL_WIDTH`, 24: bits per pixel word in the framebuffer.
- `ADDR_WIDTH`, `$clog2(NB_ANGLES*NB_LEDS)`: framebuffer address width.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `angle`  in  ANGLE_WIDTH  current angle from the angle computer; registered, changes at most once per cycle.
- `fb_rd_en`  out  1  framebuffer read strobe.
- `fb_addr`  out  ADDR_WIDTH  read address; valid while `fb_rd_en`=1.
- `fb_rdata`  in  PIXEL_WIDTH  read data; valid exactly 1 cycle after `fb_rd_en`.
- `led_sclk`  out  1  driver shift clock; drivers sample on its rising edge.
- `led_sdata`  out  1  driver serial data.
- `led_latch`  out  1  driver latch; 2-cycle high pulse per column.
- `busy`  out  1  high outside IDLE.
- `overrun`  out  1  1-cycle pulse when a requested column is dropped.

## Operation
- Change detect: `prev_angle` is registered every cycle. `angle != prev_angle` sets `pending`=1 and captures `req_angle`=`angle`.
- FSM states: IDLE, READ, WAIT, SHIFT, LATCH.
  - IDLE & `pending`: clear `pending`, load `col_angle`=`req_angle` and `led_idx`=NB_LEDS-1, go to READ.
  - READ (1 cycle): `fb_rd_en`=1, `fb_addr`=`col_angle*NB_LEDS + led_idx`, go to WAIT.
  - WAIT (1 cycle): load `fb_rdata` into the shift register, go to SHIFT.
  - SHIFT (2*PIXEL_WIDTH cycles): shift MSB first. If `led_idx`==0 go to LATCH, else decrement `led_idx` and go to READ.
  - LATCH (2 cycles): `led_latch`=1, then go to IDLE.
- LED order: index NB_LEDS-1 (farthest in the chain) first, down to 0.
- Address arithmetic: unsigned, exact in ADDR_WIDTH, no wrap. Max address is NB_ANGLES*NB_LEDS-1.
- Changes are queued while busy. A change detected while `pending` is already 1 overwrites `req_angle` and pulses `overrun`; only the latest angle is kept.
- If a change is detected in the same cycle IDLE consumes `pending`, the new request wins: `pending` stays 1 with the new `req_angle`, and the consumed one proceeds. No overrun is flagged.
- Reset values: `prev_angle`=0, `pending`=0, state IDLE, `fb_rd_en`=0, `fb_addr`=0, `led_sclk`=0, `led_sdata`=0, `led_latch`=0, `busy`=0, `overrun`=0. No column is emitted until `angle` differs from 0.
- Reset mid-column: the FSM aborts immediately to IDLE and all outputs go to reset values the next cycle. A partial shift is not latched.

## Timing
- All outputs are registered.
- `angle` first shows a new value in cycle k. `pending`=1 in k+1, `busy`=1 and state READ in k+2, so `fb_rd_en`=1 in cycle k+2.
- Bit i of a pixel occupies SHIFT cycles 2i and 2i+1:
  - cycle 2i: `led_sdata` = bit, `led_sclk`=0;
  - cycle 2i+1: `led_sclk`=1, `led_sdata` held.
- Shift rate is clk/2.
- Column length from first READ to the IDLE return is NB_LEDS*(2+2*PIXEL_WIDTH)+2 cycles; 2402 at defaults.
- The column must fit inside one angle period for overrun-free operation. This is a system constraint, not checked by this block.

## Structure
- `litspin_pkg` holds the `column_state_t` enum (IDLE, READ, WAIT, SHIFT, LATCH) and the shared `ANGLE_WIDTH` derivation.
- One sub-module, `led_shifter`:
  - parallel load of PIXEL_WIDTH bits, a bit counter, and generation of `led_sclk`/`led_sdata`;
  - a `done` pulse on the last sclk-high cycle.
- The top level holds change detect, the pending logic, the FSM and address generation.

## Test plan
Bench parameters: NB_ANGLES=8, NB_LEDS=2, PIXEL_WIDTH=4; the RAM model returns the value 0x(addr&0xF).
- Angle 0→3 at cycle k: `fb_rd_en` in k+2 with `fb_addr`=7, then `fb_addr`=6. Serial bits 0111 then 0110 on the `led_sclk` rising edges. `led_latch` high 2 cycles, `busy` falls 22 cycles after the first READ.
- After reset with `angle` held at 0 for 50 cycles: `fb_rd_en`, `led_sclk` and `busy` stay 0.
- Angle 1→2 during a column, then 2→3 also during that column:
  - `overrun` pulses once;
  - the next column reads addresses 7,6, not 5,4.
- Angle change in the cycle LATCH returns to IDLE: the next column starts with no `overrun`, and its READ follows within 2 cycles.
- Assert `rst` during SHIFT: all outputs are 0 the next cycle, no `led_latch` pulse. A subsequent change 0→5 reads addresses 11,10.
- Angle 7 (max): the addresses are 15,14 with no truncation.
